// File: rtl/locked_adder_pkg.sv
// Shared definitions for the locked-adder key loader.
//   KEY_W / DATA_W : key bus width and adder operand width
//   state_t        : loader FSM states
//   vec_t          : one self-check operand pair {a, b}
//   vec_lookup     : fixed self-check vector table (4 entries)
package locked_adder_pkg;

  localparam int KEY_W     = 32;
  localparam int DATA_W    = 16;
  localparam int VEC_DEPTH = 4;
  localparam int VEC_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } vec_t;

  // Vectors exercise: all-zero, full carry ripple, alternating bits with no
  // carry, and a carry-out with a zero sum.
  function automatic vec_t vec_lookup(input logic [VEC_IDX_W-1:0] idx);
    vec_t v;
    case (idx)
      2'd0:    v = '{a: 16'h0000, b: 16'h0000};
      2'd1:    v = '{a: 16'hFFFF, b: 16'h0001};
      2'd2:    v = '{a: 16'hAAAA, b: 16'h5555};
      default: v = '{a: 16'h8000, b: 16'h8000};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/locked_adder_key_loader_key_shift_rx.sv
// Serial key receiver: LSB-first shift register, accepted-bit counter and
// completion pulse.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   bit_i         : serial key bit
//   accept_i      : bit_i is taken this cycle
//   key_next_o    : key value including bit_i (valid as a full key when done_o)
//   done_o        : this accepted bit completes the key (combinational)
//   partial_o     : at least one bit of a key is held
module key_shift_rx #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_i,
  input  logic             accept_i,
  output logic [KEY_W-1:0] key_next_o,
  output logic             done_o,
  output logic             partial_o
);

  // Only KEY_W-1 bits need storing: the final bit is merged combinationally
  // so the completed key can be captured on the same edge it arrives.
  logic [KEY_W-2:0] sreg;
  logic [CNT_W-1:0] cnt;

  // New bit enters at the MSB; after KEY_W bits the first bit sits at [0].
  assign key_next_o = {bit_i, sreg};
  assign done_o     = accept_i && (cnt == CNT_W'(KEY_W - 1));
  assign partial_o  = (cnt != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept_i) begin
      sreg <= key_next_o[KEY_W-1:1];
      cnt  <= done_o ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/locked_adder_key_loader.sv
// Key delivery and self-check front end for the XOR/XNOR-locked adder.
// Assembles a serial key, drives it onto the locked adder key bus, then runs
// a fixed set of operand pairs through the adder and compares each result
// with a locally computed sum (including carry-out).
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   key_bit_i      : serial key bit, LSB first
//   key_valid_i    : key_bit_i valid
//   key_ready_o    : a key bit is accepted this cycle (LOAD/DONE)
//   keyinput_o     : key bus to the locked adder
//   add1_o, add2_o : self-check operands (zero when not testing)
//   result_i       : locked adder result, DATA_W+1 bits
//   test_active_o  : external mux selects add1_o/add2_o
//   busy_o         : key partially received or self-check running
//   key_ok_o       : last complete key passed every vector
//   key_fail_o     : last complete key failed a vector
module locked_adder_key_loader
  import locked_adder_pkg::*;
#(
  parameter int KEY_W   = locked_adder_pkg::KEY_W,
  parameter int DATA_W  = locked_adder_pkg::DATA_W,
  parameter int NUM_VEC = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              key_bit_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  output logic [KEY_W-1:0]  keyinput_o,
  output logic [DATA_W-1:0] add1_o,
  output logic [DATA_W-1:0] add2_o,
  input  logic [DATA_W:0]   result_i,
  output logic              test_active_o,
  output logic              busy_o,
  output logic              key_ok_o,
  output logic              key_fail_o
);

  function automatic logic [DATA_W:0] golden_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t               state;
  state_t               state_nxt;
  logic [VEC_IDX_W-1:0] vidx;
  logic                 accept;
  logic                 key_done;
  logic                 key_partial;
  logic [KEY_W-1:0]     key_next;
  logic                 vec_match;
  logic                 last_vec;
  vec_t                 first_vec;
  vec_t                 next_vec;

  assign accept    = key_valid_i && key_ready_o;
  assign vec_match = (result_i == golden_sum(add1_o, add2_o));
  assign last_vec  = (vidx == VEC_IDX_W'(NUM_VEC - 1));
  assign first_vec = vec_lookup('0);
  assign next_vec  = vec_lookup(VEC_IDX_W'(vidx + 1'b1));

  key_shift_rx #(
    .KEY_W (KEY_W),
    .CNT_W (6)
  ) u_key_shift_rx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bit_i      (key_bit_i),
    .accept_i   (accept),
    .key_next_o (key_next),
    .done_o     (key_done),
    .partial_o  (key_partial)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    key_ready_o = 1'b0;
    busy_o      = 1'b0;
    case (state)
      ST_LOAD: begin
        key_ready_o = 1'b1;
        busy_o      = key_partial;
        if (key_done) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy_o    = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy_o = 1'b1;
        if (!vec_match || last_vec) state_nxt = ST_DONE;
        else                        state_nxt = ST_DRIVE;
      end
      ST_DONE: begin
        key_ready_o = 1'b1;
        // A new bit here is bit 1 of the next key; the receiver already
        // counted it, so loading simply resumes.
        if (accept) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Registered key bus, operands and status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      keyinput_o    <= '0;
      add1_o        <= '0;
      add2_o        <= '0;
      key_ok_o      <= 1'b0;
      key_fail_o    <= 1'b0;
      test_active_o <= 1'b0;
      vidx          <= '0;
    end else begin
      if (key_done) keyinput_o <= key_next;
      case (state)
        ST_LOAD: begin
          if (key_done) begin
            vidx          <= '0;
            add1_o        <= first_vec.a;
            add2_o        <= first_vec.b;
            test_active_o <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (!vec_match || last_vec) begin
            key_fail_o    <= !vec_match;
            key_ok_o      <= vec_match;
            add1_o        <= '0;
            add2_o        <= '0;
            test_active_o <= 1'b0;
          end else begin
            vidx   <= VEC_IDX_W'(vidx + 1'b1);
            add1_o <= next_vec.a;
            add2_o <= next_vec.b;
          end
        end
        ST_DONE: begin
          if (accept) begin
            key_ok_o   <= 1'b0;
            key_fail_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_locked_adder_key_loader.sv
module tb_locked_adder_key_loader;

  localparam logic [31:0] GOOD_KEY = 32'hB80CB4AD;
  localparam logic [15:0] VA [4] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h8000};
  localparam logic [15:0] VB [4] = '{16'h0000, 16'h0001, 16'h5555, 16'h8000};

  logic        clk = 1'b0;
  logic        rst;
  logic        key_bit_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [31:0] keyinput_o;
  logic [15:0] add1_o;
  logic [15:0] add2_o;
  logic [16:0] result_i;
  logic        test_active_o;
  logic        busy_o;
  logic        key_ok_o;
  logic        key_fail_o;

  typedef struct {
    logic [31:0] key;
    logic        ok;
    logic        fail;
    int          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] prev_key = '0;
  logic        done_q   = 1'b0;
  logic        inj_en   = 1'b0;
  logic [15:0] inj_a    = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  locked_adder_key_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .key_bit_i     (key_bit_i),
    .key_valid_i   (key_valid_i),
    .key_ready_o   (key_ready_o),
    .keyinput_o    (keyinput_o),
    .add1_o        (add1_o),
    .add2_o        (add2_o),
    .result_i      (result_i),
    .test_active_o (test_active_o),
    .busy_o        (busy_o),
    .key_ok_o      (key_ok_o),
    .key_fail_o    (key_fail_o)
  );

  // Behavioural locked adder: key differences corrupt sum bits wherever the
  // operands have ones; an optional injected fault flips the carry-out.
  function automatic logic [16:0] adder_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [31:0] k);
    logic [31:0] d;
    logic [15:0] corrupt;
    logic [16:0] s;
    d       = k ^ GOOD_KEY;
    corrupt = (d[15:0] ^ d[31:16]) & (a | b);
    s       = ({1'b0, a} + {1'b0, b}) ^ {1'b0, corrupt};
    if (inj_en && a == inj_a) s[16] = ~s[16];
    return s;
  endfunction

  always_comb result_i = adder_model(add1_o, add2_o, keyinput_o);

  function automatic int first_bad(input logic [31:0] k);
    for (int i = 0; i < 4; i++)
      if (adder_model(VA[i], VB[i], k) != ({1'b0, VA[i]} + {1'b0, VB[i]})) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: one entry per completed key, popped when status rises.
  always @(negedge clk) begin
    if (!rst && (key_ok_o || key_fail_o) && !done_q) begin
      chk("status_excl", key_ok_o & key_fail_o, 0);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_key", keyinput_o, mon_e.key);
        chk("sb_ok", key_ok_o, mon_e.ok);
        chk("sb_fail", key_fail_o, mon_e.fail);
        chk("sb_cycle", cyc, mon_e.done_cyc);
      end
    end
    done_q <= key_ok_o || key_fail_o;
  end

  task automatic send_key(input logic [31:0] key, input int nbits, input int gap,
                          output int fv);
    int   waitc;
    int   gap_bad;
    int   e_cyc;
    exp_t e;
    gap_bad = 0;
    fv      = -1;
    for (int i = 0; i < nbits; i++) begin
      for (int g = 0; g < gap; g++) begin
        key_valid_i = 1'b0;
        @(negedge clk);
        if (i > 0 && !busy_o) gap_bad++;
        @(posedge clk); #1;
      end
      key_bit_i   = key[i];
      key_valid_i = 1'b1;
      waitc = 0;
      while (!key_ready_o && waitc < 50) begin
        @(posedge clk); #1;
        waitc++;
      end
      if (waitc >= 50) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      key_valid_i = 1'b0;
      if (i == 0) begin
        chk("bit1_ok_clr", key_ok_o, 0);
        chk("bit1_fail_clr", key_fail_o, 0);
        chk("bit1_busy", busy_o, 1);
      end
      if (i == 30) chk("key_hold", keyinput_o, prev_key);
    end
    if (gap > 0) chk("gap_busy", gap_bad, 0);
    if (nbits == 32) begin
      e_cyc    = cyc;
      fv       = first_bad(key);
      e.key    = key;
      e.ok     = (fv < 0);
      e.fail   = (fv >= 0);
      e.done_cyc = (fv < 0) ? e_cyc + 8 : e_cyc + 2 * fv + 2;
      sb_q.push_back(e);
      prev_key = key;
      chk("key_load", keyinput_o, key);
      chk("drive_ready", key_ready_o, 0);
    end
  endtask

  task automatic walk(input int fv, input int ncyc, input bit toggle);
    int          last_j;
    logic [31:0] exp_ops;
    logic        exp_act;
    last_j = (fv < 0) ? 7 : 2 * fv + 1;
    for (int j = 0; j < ncyc; j++) begin
      if (toggle) begin
        key_valid_i = (j % 2 == 0);
        key_bit_i   = 1'($urandom);
      end
      exp_act = (j <= last_j);
      exp_ops = exp_act ? {VA[j/2], VB[j/2]} : 32'h0;
      @(negedge clk);
      chk("vec_ops", {add1_o, add2_o}, exp_ops);
      chk("vec_active", test_active_o, exp_act);
      chk("vec_ready", key_ready_o, !exp_act);
      @(posedge clk); #1;
    end
    key_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(key_ok_o || key_fail_o) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data"}, {keyinput_o, add1_o, add2_o}, 64'h0);
    chk({tag, "_ctrl"}, {key_ok_o, key_fail_o, test_active_o, busy_o, key_ready_o}, 5'b00001);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    sb_q.delete();
    prev_key = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int fv;
    rst         = 1'b1;
    key_bit_i   = 1'b0;
    key_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Correct key, continuous valid.
    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();

    // Wrong key after a pass.
    send_key(32'h0000_0000, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();

    // Correct key with valid toggling during the self-check.
    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 8, 1'b1);
    wait_done();

    // Adder carry-out faults on later vectors.
    inj_en = 1'b1;
    inj_a  = 16'hAAAA;
    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();
    inj_a  = 16'h8000;
    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();
    inj_en = 1'b0;

    // Random wrong key.
    send_key($urandom, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();

    // Partial key stalls, then reset discards it.
    send_key(GOOD_KEY, 17, 0, fv);
    repeat (10) @(posedge clk);
    #1;
    chk("partial_busy", busy_o, 1);
    chk("partial_ready", key_ready_o, 1);
    async_reset("rst_partial");

    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 8, 1'b0);
    wait_done();

    // Reset during CHECK of vector 2.
    send_key(GOOD_KEY, 32, 0, fv);
    walk(fv, 5, 1'b0);
    async_reset("rst_check");

    // Gapped delivery, one bit every three cycles.
    send_key(GOOD_KEY, 32, 2, fv);
    walk(fv, 8, 1'b0);
    wait_done();

    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/locked_adder_key_loader.md
# locked_adder_key_loader

Key-delivery and self-check front end for the 32-key XOR/XNOR-locked 16-bit ripple-carry adder netlists. It receives the unlock key as a serial bit stream and assembles it into the 32-bit key bus that drives the locked adder. It then applies a fixed set of test vectors through the locked adder and compares each result against an internally computed golden sum. It reports key acceptance or failure to the system controller.

## Interface
- KEY_W, 32, key width; must match the locked netlist key bus.
- DATA_W, 16, adder operand width; the result is DATA_W+1 bits.
- NUM_VEC, 4, number of self-check vectors; at most the vector table depth of 4.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- key_bit_i  in  1  serial key bit, LSB first.
- key_valid_i  in  1  key_bit_i valid this cycle.
- key_ready_o  out  1  loader accepts a key bit this cycle.
- keyinput_o  out  KEY_W  key bus to the locked adder.
- add1_o  out  DATA_W  self-check operand A to the adder input mux.
- add2_o  out  DATA_W  self-check operand B to the adder input mux.
- result_i  in  DATA_W+1  locked adder result.
- test_active_o  out  1  selects add1_o/add2_o at the external adder input mux.
- busy_o  out  1  key partially received or self-check running.
- key_ok_o  out  1  last complete key passed all vectors.
- key_fail_o  out  1  last complete key failed a vector.

## Operation
- States:
  - LOAD: key_ready_o=1.
  - DRIVE: operands for vector i driven.
  - CHECK: operands held; result_i compared at the end of the cycle.
  - DONE: key_ready_o=1; status held.
- Bit acceptance:
  - A bit is accepted when key_valid_i && key_ready_o.
  - The shift register shifts right with the new bit entering the MSB, so after 32 bits sreg[0] holds the first bit received.
  - A 6-bit counter tracks accepted bits.
- The 32nd accepted bit triggers these actions:
  - keyinput_o is loaded from the completed shift value.
  - The counter clears and the vector index i is set to 0.
  - The state moves to DRIVE.
- DRIVE→CHECK is unconditional.
- CHECK compares result_i against the golden sum {1'b0,A}+{1'b0,B}, computed at full DATA_W+1 width so the carry-out is compared.
  - Mismatch: key_fail_o=1, go to DONE.
  - Match with i<NUM_VEC-1: i++, go to DRIVE.
  - Match with i=NUM_VEC-1: key_ok_o=1, go to DONE.
- A bit accepted in DONE restarts loading: key_ok_o and key_fail_o clear, the state returns to LOAD, and the bit counts as bit 1 of the new key.
- keyinput_o keeps the previous key until a new key completes.
- Key bits during DRIVE/CHECK: key_ready_o=0 and the bits are dropped, with no error.
- A partial key with no further bits: the loader waits indefinitely in LOAD with busy_o=1.
- Outputs by state:
  - test_active_o=1 only in DRIVE/CHECK.
  - busy_o=1 in DRIVE/CHECK, and in LOAD when the counter is non-zero.
  - add1_o/add2_o=0 outside DRIVE/CHECK.
- key_ok_o and key_fail_o are mutually exclusive.
- Reset values: keyinput_o=0, add1_o=0, add2_o=0, key_ok_o=0, key_fail_o=0, test_active_o=0, busy_o=0, key_ready_o=1 (LOAD). The shift register and counter are also 0.
- Reset mid-load or mid-check discards all progress.

## Timing
- Key transfer: one bit per cycle maximum; 32 accepted bits minimum per key.
- Last bit accepted at the edge ending cycle t:
  - keyinput_o is new and DRIVE v0 occurs in cycle t+1.
  - CHECK v0 occurs in t+2.
  - Vector i occupies cycles t+2i+1 and t+2i+2.
- Pass: key_ok_o is high from cycle t+2·NUM_VEC+1, which is t+9 for NUM_VEC=4.
- Fail at vector i: key_fail_o is high from cycle t+2i+3.
- The locked adder is combinational. Operands are registered and stable for 2 cycles, and the adder path must close within 1 cycle.
- All outputs are registered except key_ready_o and busy_o, which decode the state.

## Structure
- Package locked_adder_pkg:
  - KEY_W, DATA_W.
  - State enum.
  - Vector table of 4 {A,B} pairs: {0x0000,0x0000}, {0xFFFF,0x0001}, {0xAAAA,0x5555}, {0x8000,0x8000}.
- One sub-module, key_shift_rx: serial shift register, bit counter, and completion pulse.
- The FSM, vector sequencing and golden compare live in the top level.

## Test plan
- Connect the 32-key locked 16-bit adder netlist between the outputs and result_i. Shift in 0xB80CB4AD (LSB first, continuous valid) -> keyinput_o=0xB80CB4AD at t+1; key_ok_o=1 at t+9; key_fail_o=0.
- Same setup, shift in 0x00000000 -> key_fail_o=1 at the first mismatching vector; key_ok_o=0; keyinput_o=0x00000000.
- Pass a key, then shift a wrong key -> status clears when the first new bit is accepted; keyinput_o holds 0xB80CB4AD until bit 32, then key_fail_o asserts.
- Toggle key_valid_i during DRIVE/CHECK -> key_ready_o=0, no shift, no change to the running check.
- Assert rst_i asynchronously after 17 bits and again during CHECK v2 -> all outputs return to reset values immediately; the next 32 bits form a fresh key.
- Send gapped key_valid_i (1 bit every 3 cycles) -> key identical to the continuous case; busy_o=1 from bit 1.
